sr_flag_arbiter: RTL and testbench

Two-port arbiter and sequencer for a shared WIDTH-bit bank of SR-behaving flags, where each flag is stored in a T flip-flop. Two requesters, A and B, submit set/clear mask commands over a req/ack handshake. The block serialises these commands with round-robin priority, turns each accepted command into a per-bit toggle vector, and rejects illegal commands that would set and clear the same bit. It sits between control logic and the flag register as the single owner of the T inputs.

---
 rtl/sr_flag_arbiter.sv | 141 ++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Two-requester round-robin arbiter that owns the T inputs of a WIDTH-bit flag bank.
// Accepted set/clear masks become per-bit toggles; masks that both set and clear a bit are rejected.
module sr_flag_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] set_a,
  input  logic [WIDTH-1:0] clr_a,
  output logic             ack_a,
  output logic             err_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] set_b,
  input  logic [WIDTH-1:0] clr_b,
  output logic             ack_b,
  output logic             err_b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             gnt_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    ACK   = 2'd2
  } state_e;

  // T input that drives each flag toward the requested SR behaviour.
  function automatic logic [WIDTH-1:0] toggle_vec(input logic [WIDTH-1:0] set_m,
                                                  input logic [WIDTH-1:0] clr_m,
                                                  input logic [WIDTH-1:0] cur_q);
    return (set_m & ~cur_q) | (clr_m & cur_q);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic [WIDTH-1:0] set_q, set_d;
  logic [WIDTH-1:0] clr_q, clr_d;
  logic             gnt_b_q, gnt_b_d;
  logic             prio_b_q, prio_b_d;  // 1: B wins a tie
  logic             ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic             err_a_q, err_a_d, err_b_q, err_b_d;
  logic             busy_q, busy_d;
  logic             win_b_s;

  // Next-state, arbitration and flag update.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    set_d    = set_q;
    clr_d    = clr_q;
    gnt_b_d  = gnt_b_q;
    prio_b_d = prio_b_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    err_a_d  = 1'b0;
    err_b_d  = 1'b0;
    win_b_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          if (req_a && req_b) begin
            win_b_s = prio_b_q;
          end else begin
            win_b_s = req_b;
          end
          gnt_b_d  = win_b_s;
          prio_b_d = ~win_b_s;
          set_d    = win_b_s ? set_b : set_a;
          clr_d    = win_b_s ? clr_b : clr_a;
          state_d  = APPLY;
        end else begin
          state_d = IDLE;
        end
      end
      APPLY: begin
        if ((set_q & clr_q) != {WIDTH{1'b0}}) begin
          err_a_d = ~gnt_b_q;
          err_b_d = gnt_b_q;
        end else begin
          q_d     = q_q ^ toggle_vec(set_q, clr_q, q_q);
          ack_a_d = ~gnt_b_q;
          ack_b_d = gnt_b_q;
        end
        state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    qb_d   = ~q_d;
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      q_q      <= {WIDTH{1'b0}};
      qb_q     <= {WIDTH{1'b1}};
      set_q    <= {WIDTH{1'b0}};
      clr_q    <= {WIDTH{1'b0}};
      gnt_b_q  <= 1'b0;
      prio_b_q <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      qb_q     <= qb_d;
      set_q    <= set_d;
      clr_q    <= clr_d;
      gnt_b_q  <= gnt_b_d;
      prio_b_q <= prio_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      err_a_q  <= err_a_d;
      err_b_q  <= err_b_d;
      busy_q   <= busy_d;
    end
  end

  assign q     = q_q;
  assign qb    = qb_q;
  assign busy  = busy_q;
  assign gnt_b = gnt_b_q;
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign err_a = err_a_q;
  assign err_b = err_b_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed and randomized bench for sr_flag_arbiter against a transaction-level model
// that applies set/clear masks with plain boolean arithmetic.
module tb_sr_flag_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [7:0] set_a, clr_a, set_b, clr_b;
  logic       ack_a, ack_b, err_a, err_b, busy, gnt_b;
  logic [7:0] q, qb;

  int n_checks = 0;
  int n_pass   = 0;

  // model state: phase 0 = idle, 1 = applying, 2 = acknowledging
  int         m_phase;
  logic [7:0] m_q, m_set, m_clr, prev_q;
  logic       m_owner_b, m_tie_b;
  logic       m_ack_a, m_ack_b, m_err_a, m_err_b;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .set_a(set_a), .clr_a(clr_a), .ack_a(ack_a), .err_a(err_a),
    .req_b(req_b), .set_b(set_b), .clr_b(clr_b), .ack_b(ack_b), .err_b(err_b),
    .q(q), .qb(qb), .busy(busy), .gnt_b(gnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance the model by one clock edge using the inputs the bench is driving.
  task automatic model_edge();
    logic win_b;
    if (rst) begin
      m_phase = 0; m_q = 8'h00; m_owner_b = 1'b0; m_tie_b = 1'b0;
      m_ack_a = 1'b0; m_ack_b = 1'b0; m_err_a = 1'b0; m_err_b = 1'b0;
    end else if (m_phase == 0) begin
      m_ack_a = 1'b0; m_ack_b = 1'b0; m_err_a = 1'b0; m_err_b = 1'b0;
      if (req_a || req_b) begin
        win_b     = (req_a && req_b) ? m_tie_b : req_b;
        m_owner_b = win_b;
        m_tie_b   = !win_b;
        m_set     = win_b ? set_b : set_a;
        m_clr     = win_b ? clr_b : clr_a;
        m_phase   = 1;
      end
    end else if (m_phase == 1) begin
      if ((m_set & m_clr) != 8'h00) begin
        m_err_a = !m_owner_b; m_err_b = m_owner_b;
      end else begin
        m_q     = (m_q & ~m_clr) | m_set;
        m_ack_a = !m_owner_b; m_ack_b = m_owner_b;
      end
      m_phase = 2;
    end else begin
      m_ack_a = 1'b0; m_ack_b = 1'b0; m_err_a = 1'b0; m_err_b = 1'b0;
      m_phase = 0;
    end
  endtask

  // One clock: edge, model update, then compare all outputs on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("q", {24'h0, q}, {24'h0, m_q});
    check("qb", {24'h0, qb}, {24'h0, ~m_q});
    check("flags", {26'h0, busy, gnt_b, ack_a, err_a, ack_b, err_b},
          {26'h0, (m_phase != 0), m_owner_b, m_ack_a, m_err_a, m_ack_b, m_err_b});
    check("one_resp", {31'h0, ($countones({ack_a, err_a, ack_b, err_b}) <= 1)}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    set_a = 8'h00; clr_a = 8'h00; set_b = 8'h00; clr_b = 8'h00;
    cycle(); cycle();
    check("rst_q", {24'h0, q}, 32'h00);
    check("rst_qb", {24'h0, qb}, 32'hFF);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    cycle();

    // single set from A
    req_a = 1'b1; set_a = 8'hA5; clr_a = 8'h00;
    cycle(); check("t1_busy", {31'h0, busy}, 32'h1);
    cycle(); check("t1_ack", {31'h0, ack_a}, 32'h1);
    check("t1_q", {24'h0, q}, 32'hA5); check("t1_qb", {24'h0, qb}, 32'h5A);
    req_a = 1'b0;
    cycle(); check("t1_idle", {31'h0, busy}, 32'h0);

    // clear and hold from B
    req_b = 1'b1; set_b = 8'h0F; clr_b = 8'hA0;
    cycle(); cycle();
    check("t2_q", {24'h0, q}, 32'h0F); check("t2_ack", {31'h0, ack_b}, 32'h1);
    check("t2_gnt", {31'h0, gnt_b}, 32'h1);
    req_b = 1'b0;
    cycle();

    // illegal command from A
    req_a = 1'b1; set_a = 8'h11; clr_a = 8'h10;
    cycle(); cycle();
    check("t3_err", {31'h0, err_a}, 32'h1); check("t3_noack", {31'h0, ack_a}, 32'h0);
    check("t3_q", {24'h0, q}, 32'h0F);
    req_a = 1'b0;
    cycle();

    // contention after reset: A first, then B
    rst = 1'b1; cycle(); rst = 1'b0;
    req_a = 1'b1; set_a = 8'h3C; clr_a = 8'h00;
    req_b = 1'b1; set_b = 8'h01; clr_b = 8'h0C;
    cycle(); check("t4_gnt_a", {31'h0, gnt_b}, 32'h0);
    cycle(); check("t4_ack_a", {31'h0, ack_a}, 32'h1);
    req_a = 1'b0;
    cycle(); cycle(); check("t4_gnt_b", {31'h0, gnt_b}, 32'h1);
    cycle(); check("t4_ack_b", {31'h0, ack_b}, 32'h1);
    check("t4_q", {24'h0, q}, 32'h31);
    req_b = 1'b0;
    cycle();

    // reset during APPLY, then pointer favours A again
    req_a = 1'b1; set_a = 8'hFF; clr_a = 8'h00;
    cycle(); rst = 1'b1; req_a = 1'b0;
    cycle();
    check("t5_busy", {31'h0, busy}, 32'h0); check("t5_q", {24'h0, q}, 32'h00);
    check("t5_ack", {31'h0, ack_a}, 32'h0);
    rst = 1'b0;
    req_a = 1'b1; set_a = 8'h80; clr_a = 8'h00;
    req_b = 1'b1; set_b = 8'h01; clr_b = 8'h00;
    cycle(); check("t5_gnt_a", {31'h0, gnt_b}, 32'h0);
    cycle(); req_a = 1'b0;
    cycle(); cycle(); cycle(); req_b = 1'b0;
    check("t5_q2", {24'h0, q}, 32'h81);
    cycle();

    // mask change during APPLY is ignored
    prev_q = q;
    req_a = 1'b1; set_a = 8'h42; clr_a = 8'h00;
    cycle(); set_a = 8'hFF; clr_a = 8'hFF;
    cycle(); check("t6_q", {24'h0, q}, {24'h0, prev_q | 8'h42});
    req_a = 1'b0; set_a = 8'h00; clr_a = 8'h00;
    cycle();

    // randomized requesters
    for (int i = 0; i < 600; i++) begin
      if (req_a && (ack_a || err_a)) req_a = 1'b0;
      else if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1'b1; set_a = 8'($urandom);
        clr_a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (8'($urandom) & ~set_a);
      end
      if (req_b && (ack_b || err_b)) req_b = 1'b0;
      else if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1'b1; set_b = 8'($urandom);
        clr_b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (8'($urandom) & ~set_b);
      end
      rst = ($urandom_range(0, 79) == 0);
      if (rst) begin req_a = 1'b0; req_b = 1'b0; end
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
